byte_transmitter: RTL and testbench
===================================

Name: byte_transmitter

Overview:
- Transmit end of the 8-bit rdy/data/ack four-phase handshake; pairs directly with the existing byte receiver.
- Local logic pushes bytes into a small internal FIFO.
- The block drains the FIFO one byte per handshake: it raises rdy_o with the byte on data_o, waits for ack_i to rise and then fall, and releases rdy_o.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, 2..16.
- PTR_W, 2, log2(FIFO_DEPTH); pointer width.
- TIMEOUT_CYCLES, 255, REQ-state cycles without ack_i before abort; used only with TX_TIMEOUT_EN; 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk only.
- wr_data  input  8  byte to queue.
- wr_en  input  1  push wr_data this cycle.
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes; pushes ignored.
- fifo_empty  output  1  FIFO holds no bytes.
- rdy_o  output  1  handshake request; byte valid on data_o.
- data_o  output  8  byte presented to the receiver.
- ack_i  input  1  receiver acknowledge; same clock domain, no synchroniser.
- pulse_sent  output  1  one-cycle pulse per completed handshake.
- tx_err  output  1  one-cycle pulse on timeout abort; tied 0 when TX_TIMEOUT_EN is undefined.

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - Outputs: rdy_o=0, data_o=8'h00, pulse_sent=0, tx_err=0, fifo_empty=1, fifo_full=0.
  - Internal: pointers=0, occupancy=0, timeout counter=0, state=TX_IDLE.
  - Reset mid-handshake drops rdy_o at that edge and flushes all queued bytes.
- FIFO:
  - Registered occupancy counter, width PTR_W+1; pointers wrap modulo FIFO_DEPTH.
  - Push accepted iff wr_en && !fifo_full.
  - A push while full is dropped even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
  - fifo_full and fifo_empty are registered and reflect occupancy after the edge.
- States: TX_IDLE, TX_REQ, TX_HOLD, TX_GAP.
  - TX_IDLE, rdy_o=0: if !fifo_empty && ack_i==0, then at the edge: data_o<=head byte, pop, rdy_o<=1, go to TX_REQ. A stale ack_i==1 blocks launch.
  - TX_REQ, rdy_o=1, data_o held: when ack_i==1, go to TX_HOLD.
  - TX_HOLD, rdy_o=1, data_o held stable for the whole ack_i-high period (the receiver re-samples data while ack is high): when ack_i==0, then rdy_o<=0, pulse_sent<=1 for one cycle, go to TX_GAP.
  - TX_GAP, rdy_o=0 for exactly one cycle: go to TX_IDLE. This guarantees the receiver observes rdy low and returns to its wait state.
- Latency:
  - Push at edge N into an empty FIFO with an idle FSM gives rdy_o=1 after edge N+1.
  - Minimum rdy_o-low gap between bytes: 2 cycles (GAP + IDLE).
  - data_o keeps its last value while idle.
- Default state encoding returns to TX_IDLE with rdy_o=0.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to TX_REQ and increments each TX_REQ cycle while ack_i==0.
  - When the count reaches TIMEOUT_CYCLES: rdy_o<=0, tx_err<=1 for one cycle, byte discarded (no retry), no pulse_sent, go to TX_GAP.
  - TX_HOLD never times out.
- Undefined: no counter; TX_REQ waits indefinitely; tx_err is constant 0.

Test Plan:
- Single byte, receiver model with ack high for 49 cycles: push 8'hA5 into empty FIFO at edge N -> rdy_o=1 and data_o=8'hA5 after edge N+1; data_o stable while ack_i=1; rdy_o=0 and pulse_sent=1 one cycle after ack_i falls; fifo_empty=1.
- Burst: push 8'h01,8'h02,8'h03,8'h04,8'h05 on consecutive cycles with FIFO_DEPTH=4 -> first four are accepted (the first launches after one cycle), fifo_full=1 at the point of the dropped push; bytes 01..04 are delivered in order with 4 pulse_sent pulses and rdy_o low for at least 2 cycles between bytes; 05 is never delivered.
- Stale ack: hold ack_i=1, push 8'h3C -> rdy_o stays 0; release ack_i -> rdy_o=1 after the next edge with data_o=8'h3C.
- Reset mid-handshake: rst_n=0 for one cycle during TX_HOLD with 2 bytes queued -> after that edge: rdy_o=0, data_o=8'h00, fifo_empty=1, no pulse_sent; no further rdy_o until the next push.
- TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, ack_i held 0, push 8'h77 -> rdy_o high for 10 cycles, then rdy_o=0 with tx_err=1 for one cycle; next queued byte launches after the GAP.
- Push and pop same cycle: occupancy 2, push at the launch edge -> occupancy stays 2; order preserved.

Source files
------------

// File: rtl/byte_transmitter.sv
// ---------------------------------------------------------------------------
// byte_transmitter
//
// Transmit side of the 8-bit rdy/data/ack four-phase handshake. Local logic
// pushes bytes into a small FIFO. The FSM drains it one byte per handshake:
// it raises rdy_o with the byte on data_o, waits for ack_i to rise and fall,
// then releases rdy_o and holds it low for one GAP cycle before the next byte.
//
// Optional feature macro: TX_TIMEOUT_EN
//   When defined, a request left unacknowledged for TIMEOUT_CYCLES cycles in
//   TX_REQ is aborted: the byte is discarded and tx_err pulses for one cycle.
//   When undefined, TX_REQ waits indefinitely and tx_err is tied low.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   wr_data     byte to queue
//   wr_en       push wr_data this cycle (ignored while fifo_full)
//   fifo_full   FIFO holds FIFO_DEPTH bytes (registered)
//   fifo_empty  FIFO holds no bytes (registered)
//   rdy_o       handshake request; byte valid on data_o
//   data_o      byte presented to the receiver; holds last value while idle
//   ack_i       receiver acknowledge, same clock domain
//   pulse_sent  one-cycle pulse per completed handshake
//   tx_err      one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module byte_transmitter #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PTR_W          = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       rdy_o,
    output logic [7:0] data_o,
    input  logic       ack_i,
    output logic       pulse_sent,
    output logic       tx_err
);

    // Elaboration-time parameter sanity checks.
    if (FIFO_DEPTH != (1 << PTR_W) || FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_bad_depth
        $error("byte_transmitter: FIFO_DEPTH must be 2**PTR_W and within 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("byte_transmitter: TIMEOUT_CYCLES must be within 1..65535");
    end

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_HOLD = 2'd2;
    localparam logic [1:0] TX_GAP  = 2'd3;

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // ---------------- FIFO storage and bookkeeping ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             push;
    logic             pop;

    // ---------------- handshake FSM ----------------
    logic [1:0] state_q, state_d;
    logic       rdy_q,   rdy_d;
    logic [7:0] data_q,  data_d;
    logic       pulse_q, pulse_d;

`ifdef TX_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    // A full FIFO drops the push even when a pop happens in the same cycle,
    // because the decision uses the registered full flag.
    assign push = wr_en && !full_q;
    // A stale ack_i left high by the receiver blocks a new launch.
    assign pop  = (state_q == TX_IDLE) && !empty_q && !ack_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flags are registered from the next occupancy so they describe the
        // FIFO as it stands after the edge.
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        data_d  = data_q;
        pulse_d = 1'b0;
`ifdef TX_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            TX_IDLE: begin
                if (pop) begin
                    data_d  = mem[rd_ptr_q];
                    rdy_d   = 1'b1;
                    state_d = TX_REQ;
`ifdef TX_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            TX_REQ: begin
                if (ack_i) begin
                    state_d = TX_HOLD;
`ifdef TX_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    // This cycle's increment would reach TIMEOUT_CYCLES:
                    // abort and discard the byte, no retry.
                    rdy_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = TX_GAP;
                end else begin
                    tmo_d   = tmo_q + 16'd1;
`endif
                end
            end
            TX_HOLD: begin
                // data_q is untouched here so the receiver may re-sample it
                // for the whole ack-high period.
                if (!ack_i) begin
                    rdy_d   = 1'b0;
                    pulse_d = 1'b1;
                    state_d = TX_GAP;
                end
            end
            TX_GAP: begin
                // One guaranteed rdy-low cycle so the receiver sees the
                // request drop before the next launch.
                state_d = TX_IDLE;
            end
            default: begin
                rdy_d   = 1'b0;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            state_q  <= TX_IDLE;
            rdy_q    <= 1'b0;
            data_q   <= 8'h00;
            pulse_q  <= 1'b0;
`ifdef TX_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            data_q   <= data_d;
            pulse_q  <= pulse_d;
`ifdef TX_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign rdy_o      = rdy_q;
    assign data_o     = data_q;
    assign pulse_sent = pulse_q;
`ifdef TX_TIMEOUT_EN
    assign tx_err     = err_q;
`else
    assign tx_err     = 1'b0;
`endif

endmodule

// File: tb/tb_byte_transmitter.sv
// ---------------------------------------------------------------------------
// tb_byte_transmitter
//
// Drives byte_transmitter with a table of per-cycle vectors (reset, a burst
// that overflows the FIFO behind a stale ack, in-order delivery) followed by
// hand-written sequences: single byte with a long ack, stale ack launch,
// reset mid-handshake, push/pop in the same cycle and, with TX_TIMEOUT_EN
// defined, the timeout abort.
// ---------------------------------------------------------------------------
module tb_byte_transmitter;

`ifdef TX_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic       rdy_o;
    logic [7:0] data_o;
    logic       ack_i;
    logic       pulse_sent;
    logic       tx_err;

    int n_cmp = 0;
    int n_err = 0;

    byte_transmitter #(
        .FIFO_DEPTH     (4),
        .PTR_W          (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .rdy_o      (rdy_o),
        .data_o     (data_o),
        .ack_i      (ack_i),
        .pulse_sent (pulse_sent),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ack;
        logic       rdy;
        logic [7:0] data;
        logic       full;
        logic       empty;
        logic       pulse;
    } vec_t;

    vec_t vecs [25];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a request, check its byte, then ack it fully.
    task automatic deliver(input logic [7:0] exp_b);
        int waited;
        waited = 0;
        wr_en = 1'b0;
        ack_i = 1'b0;
        while (rdy_o !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        chk($sformatf("deliver %02h rdy", exp_b), rdy_o, 8'd1);
        chk($sformatf("deliver %02h data", exp_b), data_o, exp_b);
        ack_i = 1'b1;
        step();
        chk($sformatf("deliver %02h hold rdy", exp_b), rdy_o, 8'd1);
        ack_i = 1'b0;
        step();
        chk($sformatf("deliver %02h pulse", exp_b), pulse_sent, 8'd1);
        chk($sformatf("deliver %02h rdy drop", exp_b), rdy_o, 8'd0);
        $display("deliver: byte %02h handshake done", exp_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ack_i   = 1'b0;

        // rst, we, wdata, ack | rdy, data, full, empty, pulse
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        // Burst behind a stale ack: 01..04 fill the FIFO, 05 is dropped.
        vecs[1]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        // Ack released: 01 launches at this edge.
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1};
        vecs[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0};
        // 05 was dropped: nothing more launches and data_o holds 04.
        vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 25; i++) begin
            rst_n   = vecs[i].rst_n;
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            ack_i   = vecs[i].ack;
            step();
            chk($sformatf("row%0d rdy", i),   rdy_o,      vecs[i].rdy);
            chk($sformatf("row%0d data", i),  data_o,     vecs[i].data);
            chk($sformatf("row%0d full", i),  fifo_full,  vecs[i].full);
            chk($sformatf("row%0d empty", i), fifo_empty, vecs[i].empty);
            chk($sformatf("row%0d pulse", i), pulse_sent, vecs[i].pulse);
            chk($sformatf("row%0d txerr", i), tx_err,     8'd0);
            $display("row %0d: rst_n=%0b we=%0b wd=%02h ack=%0b -> rdy=%0b data=%02h full=%0b empty=%0b pulse=%0b",
                     i, rst_n, wr_en, wr_data, ack_i, rdy_o, data_o, fifo_full, fifo_empty, pulse_sent);
        end

        // Single byte, ack held high for 49 cycles.
        wr_en = 1'b1; wr_data = 8'hA5; ack_i = 1'b0;
        step();
        chk("single push rdy", rdy_o, 8'd0);
        chk("single push empty", fifo_empty, 8'd0);
        wr_en = 1'b0;
        step();
        chk("single launch rdy", rdy_o, 8'd1);
        chk("single launch data", data_o, 8'hA5);
        chk("single launch empty", fifo_empty, 8'd1);
        for (int i = 0; i < 49; i++) begin
            ack_i = 1'b1;
            step();
            chk($sformatf("single ack%0d rdy", i), rdy_o, 8'd1);
            chk($sformatf("single ack%0d data", i), data_o, 8'hA5);
            chk($sformatf("single ack%0d txerr", i), tx_err, 8'd0);
        end
        ack_i = 1'b0;
        step();
        chk("single end rdy", rdy_o, 8'd0);
        chk("single end pulse", pulse_sent, 8'd1);
        chk("single end empty", fifo_empty, 8'd1);
        step();
        chk("single gap pulse", pulse_sent, 8'd0);
        chk("single gap rdy", rdy_o, 8'd0);
        $display("single: byte A5 delivered with 49-cycle ack");

        // Stale ack blocks launch of 3C until released.
        step();
        ack_i = 1'b1; wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stale%0d rdy", i), rdy_o, 8'd0);
        end
        ack_i = 1'b0;
        step();
        chk("stale release rdy", rdy_o, 8'd1);
        chk("stale release data", data_o, 8'h3C);
        deliver(8'h3C);
        $display("stale: byte 3C launched after ack release");

        // Reset during TX_HOLD with two bytes queued.
        step();
        step();
        ack_i = 1'b0; wr_en = 1'b1;
        wr_data = 8'hB1; step();
        wr_data = 8'hB2; step();
        chk("rsthold launch data", data_o, 8'hB1);
        wr_data = 8'hB3; step();
        wr_en = 1'b0; ack_i = 1'b1;
        step();
        chk("rsthold in hold rdy", rdy_o, 8'd1);
        rst_n = 1'b0;
        step();
        chk("rsthold rdy", rdy_o, 8'd0);
        chk("rsthold data", data_o, 8'h00);
        chk("rsthold empty", fifo_empty, 8'd1);
        chk("rsthold full", fifo_full, 8'd0);
        chk("rsthold pulse", pulse_sent, 8'd0);
        rst_n = 1'b1;
        step();
        ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rsthold idle%0d rdy", i), rdy_o, 8'd0);
            chk($sformatf("rsthold idle%0d pulse", i), pulse_sent, 8'd0);
        end
        $display("reset: handshake aborted and queue flushed");

        // Occupancy 2, push at the launch edge: occupancy stays 2, so two
        // more pushes are needed to reach full.
        ack_i = 1'b1; wr_en = 1'b1;
        wr_data = 8'hC1; step();
        wr_data = 8'hC2; step();
        chk("pp pre empty", fifo_empty, 8'd0);
        chk("pp pre rdy", rdy_o, 8'd0);
        ack_i = 1'b0;
        wr_data = 8'hC3; step();
        chk("pp launch rdy", rdy_o, 8'd1);
        chk("pp launch data", data_o, 8'hC1);
        chk("pp launch full", fifo_full, 8'd0);
        wr_data = 8'hD1; step();
        chk("pp occ3 full", fifo_full, 8'd0);
        wr_data = 8'hD2; step();
        chk("pp occ4 full", fifo_full, 8'd1);
        wr_en = 1'b0;
        deliver(8'hC1);
        deliver(8'hC2);
        deliver(8'hC3);
        deliver(8'hD1);
        deliver(8'hD2);
        step();
        chk("pp drained empty", fifo_empty, 8'd1);
        $display("pushpop: order C1 C2 C3 D1 D2 preserved");

`ifdef TX_TIMEOUT_EN
        // Unacknowledged request aborts after TIMEOUT_CYCLES; next byte follows.
        step();
        step();
        ack_i = 1'b0; wr_en = 1'b1;
        wr_data = 8'h77; step();
        wr_data = 8'h78; step();
        wr_en = 1'b0;
        chk("tmo launch rdy", rdy_o, 8'd1);
        chk("tmo launch data", data_o, 8'h77);
        for (int i = 1; i < TMO; i++) begin
            step();
            chk($sformatf("tmo wait%0d rdy", i), rdy_o, 8'd1);
            chk($sformatf("tmo wait%0d txerr", i), tx_err, 8'd0);
        end
        step();
        chk("tmo abort rdy", rdy_o, 8'd0);
        chk("tmo abort txerr", tx_err, 8'd1);
        chk("tmo abort pulse", pulse_sent, 8'd0);
        step();
        chk("tmo gap txerr", tx_err, 8'd0);
        chk("tmo gap rdy", rdy_o, 8'd0);
        step();
        chk("tmo next rdy", rdy_o, 8'd1);
        chk("tmo next data", data_o, 8'h78);
        deliver(8'h78);
        $display("timeout: byte 77 aborted, byte 78 delivered");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
